pl_if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline CPU. It sits upstream of the decode stage.

- It owns the fetch PC and issues word reads to instruction memory over a req/ready/rvalid handshake.
- It buffers returned words in a 2-entry instruction queue and drives the IF/ID register.
- Decode consumes that register as `dpc4`/`inst`.
- It consumes decode's redirect and control outputs: `bpc`, `jpc`, `da`, `pcsource`, `wpcir` and `flush`.

---
 rtl/pl_if_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_pl_if_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to instruction
// memory, buffers responses in a 2-entry queue and drives the IF/ID register.
module pl_if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] da,
   input  logic [1:0]  pcsource,
   input  logic        wpcir,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic [31:0] fpc
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned QDEPTH = 2;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [XLEN-1:0]    fpc_q, fpc_d;
   logic [XLEN-1:0]    req_addr_q, req_addr_d;
   logic [XLEN-1:0]    q_pc4_q  [QDEPTH];
   logic [XLEN-1:0]    q_pc4_d  [QDEPTH];
   logic [XLEN-1:0]    q_inst_q [QDEPTH];
   logic [XLEN-1:0]    q_inst_d [QDEPTH];
   logic               head_q, head_d;
   logic               tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [XLEN-1:0]    dpc4_q, dpc4_d;
   logic [XLEN-1:0]    inst_q, inst_d;

   logic               redirect;
   logic [XLEN-1:0]    target;
   logic               handshake;
   logic               push;
   logic               pop;
   logic               q_empty;

   // Decode redirect: pcsource only matters when the pipeline may advance.
   always_comb begin
      redirect = wpcir & (pcsource != 2'b00);
      unique case (pcsource)
         2'b01:   target = bpc;
         2'b10:   target = da;
         2'b11:   target = jpc;
         default: target = fpc_q;
      endcase
   end

   assign q_empty   = (count_q == '0);
   assign handshake = imem_req & imem_ready;
   // A response landing in the redirect cycle belongs to the old path.
   assign push      = (state_q == ST_WAIT) & imem_rvalid & ~redirect;
   assign pop       = wpcir & ~flush & ~redirect & ~q_empty;

   // Fetch FSM: state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Fetch FSM: next state. Redirects steer to DROP whenever a request
   // will still be outstanding after this edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (handshake) begin
               state_d = redirect ? ST_DROP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               state_d = ST_REQ;
            end else if (redirect) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fetch FSM: outputs depend on registered state and count only.
   always_comb begin
      imem_req = 1'b0;
      if (state_q == ST_REQ) begin
         imem_req = (count_q < CNT_W'(QDEPTH));
      end
   end

   assign imem_addr = fpc_q;

   // Fetch PC and captured request address.
   always_comb begin
      fpc_d      = fpc_q;
      req_addr_d = req_addr_q;
      if (handshake) begin
         req_addr_d = fpc_q;
      end
      if (redirect) begin
         fpc_d = target;
      end else if (handshake) begin
         fpc_d = fpc_q + XLEN'(4);
      end
   end

   // Instruction queue: a redirect empties it, otherwise push/pop in order.
   always_comb begin
      q_pc4_d  = q_pc4_q;
      q_inst_d = q_inst_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      if (redirect) begin
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = '0;
      end else begin
         if (push) begin
            q_pc4_d[tail_q]  = req_addr_q + XLEN'(4);
            q_inst_d[tail_q] = imem_rdata;
            tail_d           = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // IF/ID register: bubble on flush/redirect or empty queue, hold on stall.
   always_comb begin
      dpc4_d = dpc4_q;
      inst_d = inst_q;
      if (wpcir) begin
         if (flush | redirect) begin
            inst_d = NOP_INST;
         end else if (!q_empty) begin
            dpc4_d = q_pc4_q[head_q];
            inst_d = q_inst_q[head_q];
         end else begin
            inst_d = NOP_INST;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fpc_q      <= RESET_PC;
         req_addr_q <= RESET_PC;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         count_q    <= '0;
         dpc4_q     <= '0;
         inst_q     <= NOP_INST;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc4_q[i]  <= '0;
            q_inst_q[i] <= '0;
         end
      end else begin
         fpc_q      <= fpc_d;
         req_addr_q <= req_addr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         dpc4_q     <= dpc4_d;
         inst_q     <= inst_d;
         q_pc4_q    <= q_pc4_d;
         q_inst_q   <= q_inst_d;
      end
   end

   assign dpc4 = dpc4_q;
   assign inst = inst_q;
   assign fpc  = fpc_q;

endmodule

// File: tb/tb_pl_if_fetch.sv
// Self-checking bench for pl_if_fetch: directed scenarios plus a randomized
// run checked against a program-order fetch-stream model.
module tb_pl_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] bpc, jpc, da;
   logic [1:0]  pcsource;
   logic        wpcir, flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] dpc4, inst, fpc;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int mem_lat = 1;
   bit mem_rdy_rand = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t       pend[$];
   bit          hs_pend = 1'b0;
   logic [31:0] hs_addr = '0;

   pl_if_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
      .clock(clock), .resetn(resetn), .bpc(bpc), .jpc(jpc), .da(da),
      .pcsource(pcsource), .wpcir(wpcir), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dpc4(dpc4), .inst(inst), .fpc(fpc)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Instruction memory: in-order responses, word at addr is addr ^ KEY.
   always @(negedge clock) begin
      if (!resetn) begin
         pend.delete();
         hs_pend     = 1'b0;
         imem_ready  = 1'b0;
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end else begin
         if (imem_rvalid) void'(pend.pop_front());
         if (hs_pend) begin
            int lat;
            lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
            pend.push_back('{hs_addr, cyc + lat});
         end
         imem_ready = mem_rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
         hs_pend    = imem_req && imem_ready;
         hs_addr    = imem_addr;
         if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ KEY;
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int lat, input bit rdy_rand);
      resetn = 1'b0; wpcir = 1'b1; flush = 1'b0; pcsource = 2'b00;
      bpc = '0; jpc = '0; da = '0;
      mem_lat = lat; mem_rdy_rand = rdy_rand;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // Step until IF/ID loads a real instruction (inst not a bubble or dpc4 moved).
   task automatic wait_load(input logic [31:0] prev_d, output logic [31:0] d,
                            output logic [31:0] i, output bit timeout);
      timeout = 1'b1;
      d = prev_d; i = NOP;
      for (int n = 0; n < 40; n++) begin
         step();
         if (inst !== NOP || dpc4 !== prev_d) begin
            d = dpc4; i = inst; timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset(1, 1'b0);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
      checks++; if (fpc !== 32'h0) begin errors++; $display("FAIL rst_fpc got %h exp 0", fpc); end
      checks++; if (dpc4 !== 32'h0) begin errors++; $display("FAIL rst_dpc4 got %h exp 0", dpc4); end
      checks++; if (inst !== NOP) begin errors++; $display("FAIL rst_inst got %h exp %h", inst, NOP); end
   endtask

   task automatic test_sequential();
      logic [31:0] ed, ei;
      do_reset(1, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         step();
         checks++;
         if (imem_req !== ((e % 2) == 1)) begin
            errors++; $display("FAIL seq_req e=%0d got %b exp %b", e, imem_req, (e % 2) == 1);
         end
         if ((e % 2) == 1) begin
            checks++;
            if (imem_addr !== 32'(4 * ((e - 1) / 2))) begin
               errors++; $display("FAIL seq_addr e=%0d got %h exp %h", e, imem_addr, 32'(4 * ((e - 1) / 2)));
            end
         end
         if (e >= 4 && (e % 2) == 0) begin
            ed = 32'(2 * e - 4); ei = 32'(2 * e - 8) ^ KEY;
         end else begin
            ed = (e < 4) ? 32'h0 : 32'(2 * (e - 1) - 4); ei = NOP;
         end
         checks++;
         if (dpc4 !== ed || inst !== ei) begin
            errors++; $display("FAIL seq_ifid e=%0d got %h/%h exp %h/%h", e, dpc4, inst, ed, ei);
         end
      end
   endtask

   task automatic test_stall_fill();
      wpcir = 1'b0;
      repeat (10) step();
      checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", dut.count_q); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
      checks++; if (fpc !== 32'h1C) begin errors++; $display("FAIL stall_fpc got %h exp 1c", fpc); end
      checks++; if (dpc4 !== 32'h14 || inst !== (32'h10 ^ KEY)) begin
         errors++; $display("FAIL stall_hold got %h/%h exp 14/%h", dpc4, inst, 32'h10 ^ KEY);
      end
      wpcir = 1'b1;
      step();
      checks++; if (dpc4 !== 32'h18 || inst !== (32'h14 ^ KEY)) begin
         errors++; $display("FAIL stall_pop0 got %h/%h exp 18/%h", dpc4, inst, 32'h14 ^ KEY);
      end
      step();
      checks++; if (dpc4 !== 32'h1C || inst !== (32'h18 ^ KEY)) begin
         errors++; $display("FAIL stall_pop1 got %h/%h exp 1c/%h", dpc4, inst, 32'h18 ^ KEY);
      end
   endtask

   task automatic test_redirect_wait();
      logic [31:0] d, i;
      bit to;
      do_reset(3, 1'b0);
      step(); step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_req got %b exp 0", imem_req); end
      pcsource = 2'b01; bpc = 32'h100;
      step();
      pcsource = 2'b00;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || fpc !== 32'h100) begin
         errors++; $display("FAIL rw_redir got req=%b addr=%h fpc=%h exp 0/100/100", imem_req, imem_addr, fpc);
      end
      checks++; if (inst !== NOP || dpc4 !== 32'h0) begin
         errors++; $display("FAIL rw_bubble got %h/%h exp 0/%h", dpc4, inst, NOP);
      end
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req got %b exp 0", imem_req); end
      wait_load(32'h0, d, i, to);
      checks++; if (to || d !== 32'h104 || i !== (32'h100 ^ KEY)) begin
         errors++; $display("FAIL rw_first got %h/%h timeout=%b exp 104/%h", d, i, to, 32'h100 ^ KEY);
      end
   endtask

   task automatic test_jump();
      logic [31:0] d, i;
      bit to;
      do_reset(1, 1'b0);
      step();
      pcsource = 2'b10; da = 32'h200;
      step();
      pcsource = 2'b00;
      checks++; if (imem_req !== 1'b0 || fpc !== 32'h200) begin
         errors++; $display("FAIL jr_redir got req=%b fpc=%h exp 0/200", imem_req, fpc);
      end
      wait_load(32'h0, d, i, to);
      checks++; if (to || d !== 32'h204 || i !== (32'h200 ^ KEY)) begin
         errors++; $display("FAIL jr_first got %h/%h timeout=%b exp 204/%h", d, i, to, 32'h200 ^ KEY);
      end
      pcsource = 2'b11; jpc = 32'h300;
      step();
      pcsource = 2'b00;
      checks++; if (inst !== NOP || fpc !== 32'h300) begin
         errors++; $display("FAIL j_redir got inst=%h fpc=%h exp %h/300", inst, fpc, NOP);
      end
      wait_load(32'h204, d, i, to);
      checks++; if (to || d !== 32'h304 || i !== (32'h300 ^ KEY)) begin
         errors++; $display("FAIL j_first got %h/%h timeout=%b exp 304/%h", d, i, to, 32'h300 ^ KEY);
      end
      wpcir = 1'b0; pcsource = 2'b01; bpc = 32'h500;
      repeat (10) step();
      checks++; if (fpc !== 32'h30C || dut.count_q !== 2'd2 || dpc4 !== 32'h304) begin
         errors++; $display("FAIL sb_hold got fpc=%h cnt=%0d dpc4=%h exp 30c/2/304", fpc, dut.count_q, dpc4);
      end
      pcsource = 2'b00; wpcir = 1'b1;
      step();
      checks++; if (dpc4 !== 32'h308 || inst !== (32'h304 ^ KEY)) begin
         errors++; $display("FAIL sb_pop0 got %h/%h exp 308/%h", dpc4, inst, 32'h304 ^ KEY);
      end
      step();
      checks++; if (dpc4 !== 32'h30C || inst !== (32'h308 ^ KEY)) begin
         errors++; $display("FAIL sb_pop1 got %h/%h exp 30c/%h", dpc4, inst, 32'h308 ^ KEY);
      end
   endtask

   task automatic test_flush();
      logic [31:0] d, i;
      bit to;
      do_reset(1, 1'b0);
      wpcir = 1'b0;
      repeat (10) step();
      wpcir = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (inst !== NOP || dpc4 !== 32'h0 || dut.count_q !== 2'd2) begin
         errors++; $display("FAIL fl_nopop got %h/%h cnt=%0d exp 0/%h/2", dpc4, inst, dut.count_q, NOP);
      end
      step();
      checks++; if (dpc4 !== 32'h4 || inst !== KEY) begin
         errors++; $display("FAIL fl_pop0 got %h/%h exp 4/%h", dpc4, inst, KEY);
      end
      step();
      checks++; if (dpc4 !== 32'h8 || inst !== (32'h4 ^ KEY) || imem_req !== 1'b0) begin
         errors++; $display("FAIL fl_pop1 got %h/%h req=%b exp 8/%h/0", dpc4, inst, imem_req, 32'h4 ^ KEY);
      end
      flush = 1'b1; pcsource = 2'b11; jpc = 32'h300;
      step();
      flush = 1'b0; pcsource = 2'b00;
      checks++; if (inst !== NOP || dpc4 !== 32'h8 || dut.count_q !== 2'd0) begin
         errors++; $display("FAIL flr_ifid got %h/%h cnt=%0d exp 8/%h/0", dpc4, inst, dut.count_q, NOP);
      end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
         errors++; $display("FAIL flr_req got %b/%h exp 1/300", imem_req, imem_addr);
      end
      wait_load(32'h8, d, i, to);
      checks++; if (to || d !== 32'h304 || i !== (32'h300 ^ KEY)) begin
         errors++; $display("FAIL flr_first got %h/%h timeout=%b exp 304/%h", d, i, to, 32'h300 ^ KEY);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1, 1'b0);
      repeat (4) step();
      wpcir = 1'b0;
      step(); step();
      checks++; if (fpc !== 32'hC || dut.count_q !== 2'd1 || dpc4 !== 32'h4) begin
         errors++; $display("FAIL mr_pre got fpc=%h cnt=%0d dpc4=%h exp c/1/4", fpc, dut.count_q, dpc4);
      end
      resetn = 1'b0;
      #2;
      checks++; if (dpc4 !== 32'h0 || inst !== NOP || fpc !== 32'h0) begin
         errors++; $display("FAIL mr_regs got %h/%h/%h exp 0/%h/0", dpc4, inst, fpc, NOP);
      end
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || dut.count_q !== 2'd0) begin
         errors++; $display("FAIL mr_fetch got req=%b addr=%h cnt=%0d exp 0/0/0", imem_req, imem_addr, dut.count_q);
      end
      do_reset(1, 1'b0);
      repeat (4) step();
      checks++; if (dpc4 !== 32'h4 || inst !== KEY) begin
         errors++; $display("FAIL mr_restart got %h/%h exp 4/%h", dpc4, inst, KEY);
      end
   endtask

   // Random traffic: IF/ID must deliver the program-order stream from the last
   // redirect target, with bubbles only when allowed and bounded starvation.
   task automatic test_random();
      logic [31:0] exp_pc, m_dpc4, m_inst, tgt;
      bit          w, f;
      logic [1:0]  ps;
      int          bubble_run;
      do_reset(0, 1'b1);
      exp_pc = 32'h0; m_dpc4 = 32'h0; m_inst = NOP; bubble_run = 0;
      for (int n = 0; n < 600; n++) begin
         w  = ($urandom_range(0, 9) < 8);
         f  = ($urandom_range(0, 9) == 0);
         ps = ($urandom_range(0, 19) < 17) ? 2'b00 : 2'($urandom_range(1, 3));
         bpc = 32'h1000 | (32'($urandom_range(0, 1023)) << 2);
         da  = 32'h1000 | (32'($urandom_range(0, 1023)) << 2);
         jpc = 32'h1000 | (32'($urandom_range(0, 1023)) << 2);
         tgt = (ps == 2'b01) ? bpc : (ps == 2'b10) ? da : jpc;
         wpcir = w; flush = f; pcsource = ps;
         step();
         if (!w) begin
            checks++; if (dpc4 !== m_dpc4 || inst !== m_inst) begin
               errors++; $display("FAIL rnd_hold n=%0d got %h/%h exp %h/%h", n, dpc4, inst, m_dpc4, m_inst);
            end
         end else if (f || ps != 2'b00) begin
            checks++; if (dpc4 !== m_dpc4 || inst !== NOP) begin
               errors++; $display("FAIL rnd_bubble n=%0d got %h/%h exp %h/%h", n, dpc4, inst, m_dpc4, NOP);
            end
            m_inst = NOP;
            if (ps != 2'b00) begin
               exp_pc = tgt;
               checks++; if (fpc !== tgt) begin
                  errors++; $display("FAIL rnd_target n=%0d got %h exp %h", n, fpc, tgt);
               end
            end
         end else if (inst === NOP && dpc4 === m_dpc4) begin
            m_inst = NOP;
            bubble_run++;
            checks++; if (bubble_run >= 40) begin
               errors++; $display("FAIL rnd_starve n=%0d got %0d empty cycles exp <40", n, bubble_run);
               bubble_run = 0;
            end
         end else begin
            checks++; if (dpc4 !== exp_pc + 32'd4 || inst !== (exp_pc ^ KEY)) begin
               errors++; $display("FAIL rnd_load n=%0d got %h/%h exp %h/%h", n, dpc4, inst, exp_pc + 32'd4, exp_pc ^ KEY);
            end
            m_dpc4 = exp_pc + 32'd4; m_inst = exp_pc ^ KEY;
            exp_pc = exp_pc + 32'd4;
            bubble_run = 0;
         end
      end
      wpcir = 1'b1; flush = 1'b0; pcsource = 2'b00;
   endtask

   initial begin
      resetn = 1'b0; wpcir = 1'b1; flush = 1'b0; pcsource = 2'b00;
      bpc = '0; jpc = '0; da = '0;
      test_reset();
      test_sequential();
      test_stall_fill();
      test_redirect_wait();
      test_jump();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
